// File: rtl/dense_layer_combine.sv
// dense_layer_combine: sums BANKS partial-sum slices plus a per-neuron bias,
// applies the selected activation and stores NEURONS results in an internal
// buffer that the next layer reads through a registered port.
// Optional macro DENSE_COMBINE_SAT_EN: saturate the wide sum to W bits and
// report clamps on ovf_flag (default build wraps and ties ovf_flag to 0).
module dense_layer_combine #(
  parameter int NEURONS    = 100,
  parameter int BANKS      = 2,
  parameter int INT_W      = 10,
  parameter int FRAC_W     = 10,
  parameter int ADDR_W     = 7,
  parameter int RD_LATENCY = 4,
  parameter int ACT_MODE   = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [BANKS-1:0]               banks_done,
  output logic [ADDR_W-1:0]              part_addr,
  output logic                           part_en,
  input  logic [BANKS*(INT_W+FRAC_W)-1:0] part_data,
  output logic [ADDR_W-1:0]              bias_addr,
  input  logic [INT_W+FRAC_W-1:0]        bias_data,
  input  logic                           out_rd_en,
  input  logic [ADDR_W-1:0]              out_rd_addr,
  output logic [INT_W+FRAC_W-1:0]        out_rd_data,
  output logic                           busy,
  output logic                           done,
  output logic                           ovf_flag
);

  localparam int W     = INT_W + FRAC_W;
  localparam int CNT_W = $clog2(RD_LATENCY + 1);
`ifdef DENSE_COMBINE_SAT_EN
  // Headroom so the full BANKS+1 term sum never overflows before clamping.
  localparam int ACC_W = W + $clog2(BANKS + 1);
`else
  // Wrapping keeps only the low W bits, which a W-bit adder already yields.
  localparam int ACC_W = W;
`endif

  typedef enum logic [2:0] {IDLE, WAIT_READ, ACCUM, ACT, WRITE, DONE} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           wait_cnt;
  logic                       accept;
  logic                       last_neuron;
  logic                       vld_p0, vld_p1;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [W-1:0]        red_val;
  logic signed [W-1:0]        red_p0;
  logic signed [W-1:0]        act_p1;
  logic [W-1:0]               mem [NEURONS];

  function automatic logic signed [ACC_W-1:0] sext(input logic [W-1:0] v);
    return ACC_W'($signed(v));
  endfunction

`ifdef DENSE_COMBINE_SAT_EN
  function automatic logic ovf_det(input logic signed [ACC_W-1:0] s);
    return s[ACC_W-1:W-1] != {(ACC_W-W+1){s[ACC_W-1]}};
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [ACC_W-1:0] s);
    if (!ovf_det(s)) return s[W-1:0];
    if (s[ACC_W-1]) return {1'b1, {(W-1){1'b0}}};
    return {1'b0, {(W-1){1'b1}}};
  endfunction
`endif

  function automatic logic signed [W-1:0] act_fn(input logic signed [W-1:0] v);
    if (ACT_MODE == 1 && v[W-1]) return '0;
    return v;
  endfunction

  assign accept      = (state_q == IDLE) && start && (&banks_done);
  assign last_neuron = (part_addr == ADDR_W'(NEURONS - 1));
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign bias_addr   = part_addr;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = WAIT_READ;
      WAIT_READ: if (wait_cnt == CNT_W'(RD_LATENCY - 1)) state_d = ACCUM;
      ACCUM:     state_d = ACT;
      ACT:       state_d = WRITE;
      WRITE:     state_d = last_neuron ? DONE : WAIT_READ;
      DONE:      if (!start) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Control registers: neuron address, read enable, latency counter, done, valids
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      part_addr <= '0;
      part_en   <= 1'b0;
      wait_cnt  <= '0;
      done      <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p0 <= (state_q == ACCUM);
      vld_p1 <= vld_p0;
      case (state_q)
        IDLE: if (accept) begin
          part_addr <= '0;
          part_en   <= 1'b1;
          wait_cnt  <= '0;
          done      <= 1'b0;
        end
        WAIT_READ: wait_cnt <= wait_cnt + CNT_W'(1);
        WRITE: begin
          wait_cnt <= '0;
          if (last_neuron) begin
            part_en <= 1'b0;
            done    <= 1'b1;
          end else begin
            part_addr <= part_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Wide signed sum of bias and every bank slice
  always_comb begin
    acc_sum = sext(bias_data);
    for (int k = 0; k < BANKS; k++) acc_sum = acc_sum + sext(part_data[k*W +: W]);
  end

`ifdef DENSE_COMBINE_SAT_EN
  assign red_val = sat_w(acc_sum);

  // Sticky clamp flag, cleared when a new pass is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 ovf_flag <= 1'b0;
    else if (accept)                              ovf_flag <= 1'b0;
    else if (state_q == ACCUM && ovf_det(acc_sum)) ovf_flag <= 1'b1;
  end
`else
  assign red_val  = acc_sum;
  assign ovf_flag = 1'b0;
`endif

  // ---- stage p0: reduced sum captured in ACCUM ----
  always_ff @(posedge clk) begin
    if (state_q == ACCUM) red_p0 <= red_val;
  end

  // ---- stage p1: activation applied in ACT ----
  always_ff @(posedge clk) begin
    if (vld_p0) act_p1 <= act_fn(red_p0);
  end

  // Buffer write in WRITE (vld_p1 marks that cycle)
  always_ff @(posedge clk) begin
    if (vld_p1) mem[part_addr] <= act_p1;
  end

  // Registered read port; out-of-range addresses read as zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_rd_data <= '0;
    else if (out_rd_en)
      out_rd_data <= (int'(out_rd_addr) < NEURONS) ? mem[out_rd_addr] : '0;
  end

endmodule

// File: tb/tb_dense_layer_combine.sv
// Directed bench for dense_layer_combine: a default instance (2 banks, ReLU)
// and a small 4-bank identity instance, each fed by a latency-accurate model.
module tb_dense_layer_combine;

  localparam int W = 20;
`ifdef DENSE_COMBINE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, start2;
  int   mode;
  int   total = 0;
  int   bad   = 0;

  logic [1:0]   banks_done;
  logic [6:0]   part_addr1, bias_addr1, out_rd_addr1;
  logic         part_en1, out_rd_en1, busy1, done1, ovf1;
  logic [2*W-1:0] part_data1;
  logic [W-1:0] bias_data1, out_rd_data1;

  logic [3:0]   banks_done2;
  logic [2:0]   part_addr2, bias_addr2, out_rd_addr2;
  logic         part_en2, out_rd_en2, busy2, done2, ovf2;
  logic [4*W-1:0] part_data2;
  logic [W-1:0] bias_data2, out_rd_data2;

  dense_layer_combine dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .banks_done(banks_done),
    .part_addr(part_addr1), .part_en(part_en1), .part_data(part_data1),
    .bias_addr(bias_addr1), .bias_data(bias_data1),
    .out_rd_en(out_rd_en1), .out_rd_addr(out_rd_addr1), .out_rd_data(out_rd_data1),
    .busy(busy1), .done(done1), .ovf_flag(ovf1)
  );

  dense_layer_combine #(.NEURONS(8), .BANKS(4), .ADDR_W(3), .RD_LATENCY(2), .ACT_MODE(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .banks_done(banks_done2),
    .part_addr(part_addr2), .part_en(part_en2), .part_data(part_data2),
    .bias_addr(bias_addr2), .bias_data(bias_data2),
    .out_rd_en(out_rd_en2), .out_rd_addr(out_rd_addr2), .out_rd_data(out_rd_data2),
    .busy(busy2), .done(done2), .ovf_flag(ovf2)
  );

  // Bank/bias source values in Q10.10 raw units for each stimulus mode
  function automatic int v0(int m, int n);
    if (m == 0) return n * 1024;
    if (m == 1) return 409600;
    return n * 256;
  endfunction
  function automatic int v1(int m, int n);
    if (m == 0) return 512;
    if (m == 1) return 409600;
    return -10240 + 0 * n;
  endfunction
  function automatic int vb(int m, int n);
    if (m == 0) return -1024 + 0 * n;
    if (m == 1) return 307200;
    return 3072;
  endfunction

  // Reference result for the default instance (ReLU)
  function automatic logic [W-1:0] expv(int m, int n);
    int s;
    logic [W-1:0] r;
    s = v0(m, n) + v1(m, n) + vb(m, n);
    if (SAT && s > 524287)  s = 524287;
    if (SAT && s < -524288) s = -524288;
    r = W'(s);
    if (r[W-1]) r = '0;
    return r;
  endfunction

  // Read-latency model: data follows the address RD_LATENCY edges later
  logic [6:0] ppipe [4];
  logic [6:0] bpipe [4];
  always @(posedge clk) begin
    ppipe[0] <= part_addr1;
    bpipe[0] <= bias_addr1;
    for (int i = 1; i < 4; i++) begin
      ppipe[i] <= ppipe[i-1];
      bpipe[i] <= bpipe[i-1];
    end
  end
  always_comb begin
    part_data1 = {W'(v1(mode, int'(ppipe[3]))), W'(v0(mode, int'(ppipe[3])))};
    bias_data1 = W'(vb(mode, int'(bpipe[3])));
  end
  assign part_data2 = {W'(-4096), W'(3072), W'(-2048), W'(1024)};
  assign bias_data2 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd1(input int a, output logic [W-1:0] d);
    out_rd_en1   = 1'b1;
    out_rd_addr1 = 7'(a);
    tick();
    out_rd_en1 = 1'b0;
    d = out_rd_data1;
  endtask

  // Counts edges from the accepting edge (1) to the edge that raises done
  task automatic run1(output int cyc);
    tick();
    cyc = 1;
    chk("accept_busy", {31'd0, busy1}, 32'd1);
    while (!done1 && cyc < 2000) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    logic [W-1:0] d;
    int cyc, k;
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 0;
    banks_done = 2'b00; banks_done2 = 4'h0;
    out_rd_en1 = 1'b0; out_rd_addr1 = '0; out_rd_en2 = 1'b0; out_rd_addr2 = '0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_ovf", {31'd0, ovf1}, 32'd0);
    chk("rst_part_en", {31'd0, part_en1}, 32'd0);
    chk("rst_part_addr", {25'd0, part_addr1}, 32'd0);
    chk("rst_rd_data", {12'd0, out_rd_data1}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Not all banks done: must stay idle
    banks_done = 2'b01; start = 1'b1;
    repeat (20) tick();
    chk("idle_busy", {31'd0, busy1}, 32'd0);
    chk("idle_part_en", {31'd0, part_en1}, 32'd0);
    banks_done = 2'b11;
    run1(cyc);
    chk("pass1_cycles", cyc, 32'd701);
    chk("pass1_busy", {31'd0, busy1}, 32'd0);
    chk("pass1_ovf", {31'd0, ovf1}, 32'd0);
    repeat (5) tick();
    chk("hold_done", {31'd0, done1}, 32'd1);
    chk("hold_busy", {31'd0, busy1}, 32'd0);
    start = 1'b0;
    tick();
    chk("idle_done_kept", {31'd0, done1}, 32'd1);

    rd1(0, d);   chk("buf0", {12'd0, d}, {12'd0, expv(0, 0)});
    rd1(3, d);   chk("buf3", {12'd0, d}, 32'h00A00);
    rd1(50, d);  chk("buf50", {12'd0, d}, {12'd0, expv(0, 50)});
    rd1(99, d);  chk("buf99", {12'd0, d}, {12'd0, expv(0, 99)});
    out_rd_addr1 = 7'd5;
    tick();
    chk("rd_hold", {12'd0, out_rd_data1}, {12'd0, expv(0, 99)});
    rd1(120, d); chk("buf120", {12'd0, d}, 32'd0);
    out_rd_en1 = 1'b1; out_rd_addr1 = 7'd3;
    #1;
    chk("rd_before_edge", {12'd0, out_rd_data1}, 32'd0);
    tick();
    out_rd_en1 = 1'b0;
    chk("rd_after_edge", {12'd0, out_rd_data1}, 32'h00A00);

    // Overflowing sum: clamp or wrap depending on build
    mode = 1; start = 1'b1;
    run1(cyc);
    chk("sat_cycles", cyc, 32'd701);
    chk("sat_ovf", {31'd0, ovf1}, {31'd0, SAT});
    rd1(5, d);   chk("sat_buf5", {12'd0, d}, {12'd0, expv(1, 5)});
    start = 1'b0;
    tick();

    // Abort mid-pass with reset, then rerun completely
    mode = 2; start = 1'b1;
    tick();
    chk("ovf_cleared", {31'd0, ovf1}, 32'd0);
    k = 0;
    while (part_addr1 != 7'd50 && k < 1000) begin
      tick();
      k++;
    end
    chk("reach_n50", {31'd0, (k < 1000)}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy1}, 32'd0);
    chk("abort_done", {31'd0, done1}, 32'd0);
    chk("abort_part_en", {31'd0, part_en1}, 32'd0);
    chk("abort_addr", {25'd0, part_addr1}, 32'd0);
    tick();
    reset_n = 1'b1;
    run1(cyc);
    chk("rerun_cycles", cyc, 32'd701);
    for (int n = 0; n < 100; n++) begin
      rd1(n, d);
      chk($sformatf("rerun_buf%0d", n), {12'd0, d}, {12'd0, expv(2, n)});
    end
    start = 1'b0;

    // Four banks, identity activation, short latency
    banks_done2 = 4'hF; start2 = 1'b1;
    tick();
    cyc = 1;
    while (!done2 && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("b4_cycles", cyc, 32'd41);
    chk("b4_ovf", {31'd0, ovf2}, 32'd0);
    start2 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      out_rd_en2 = 1'b1; out_rd_addr2 = 3'(n);
      tick();
      out_rd_en2 = 1'b0;
      chk($sformatf("b4_buf%0d", n), {12'd0, out_rd_data2}, 32'h000FF800);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dense_layer_combine.md
Name: dense_layer_combine

Overview:
- Parametrised successor to the fixed two-bank dense-layer combiner.
- Reads BANKS parallel partial-sum vectors from upstream matrixmult units, adds a per-neuron bias, applies a selectable activation and writes NEURONS results into an internal output buffer.
- Sits between the matrixmult banks and the next layer. After done, the next layer reads results through a registered read port.

Parameters:
- NEURONS, 100: output neurons per pass (1..2^ADDR_W).
- BANKS, 2: partial-sum banks summed per neuron (>=1).
- INT_W, 10: integer bits of the signed fixed-point word.
- FRAC_W, 10: fraction bits; W = INT_W+FRAC_W.
- ADDR_W, 7: neuron/bias/output address width.
- RD_LATENCY, 4: cycles from part_addr/bias_addr change to valid part_data/bias_data (>=1).
- ACT_MODE, 1: 0 = identity, 1 = ReLU.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level request; sampled only in IDLE.
- banks_done  in  BANKS  per-bank matrixmult done flags.
- part_addr  out  ADDR_W  neuron index driven to all banks.
- part_en  out  1  read enable to all banks.
- part_data  in  BANKS*W  bank k occupies bits [k*W +: W], signed.
- bias_addr  out  ADDR_W  bias ROM address (always equals part_addr).
- bias_data  in  W  signed bias.
- out_rd_en  in  1  output buffer read enable.
- out_rd_addr  in  ADDR_W  output buffer read address.
- out_rd_data  out  W  registered read data.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  pass complete.
- ovf_flag  out  1  sticky overflow seen this pass.

Behaviour:
- Reset (reset_n low, async): state=IDLE; part_addr=0; bias_addr=0; part_en=0; busy=0; done=0; ovf_flag=0; out_rd_data=0. Buffer contents are not cleared.
- IDLE → WAIT_READ when start=1 and &banks_done=1.
  - On this transition: part_addr=0, part_en=1, done=0, ovf_flag=0.
  - If start=1 but any bank is not done, remain in IDLE.
- WAIT_READ: count RD_LATENCY cycles, then → ACCUM.
- ACCUM (1 cycle):
  - Register a signed sum of all BANKS slices plus bias_data.
  - Sum width is W+clog2(BANKS+1), sign-extended, so no intermediate overflow.
  - Reduce the sum to W bits as described under Optional Feature.
- ACT (1 cycle): ACT_MODE=1 → negative values become 0. ACT_MODE=0 → pass through.
- WRITE (1 cycle): write the result to buffer[part_addr].
  - If part_addr < NEURONS-1: increment part_addr and go to WAIT_READ.
  - Otherwise: part_en=0 and go to DONE.
- Per-neuron time: RD_LATENCY+3 cycles. Total from start acceptance to done=1: 1+NEURONS*(RD_LATENCY+3) cycles (defaults: 701).
- DONE:
  - done=1, busy=0.
  - When start=0 → IDLE; done stays 1 until the next start is accepted.
  - start held high keeps the block in DONE; there is no automatic re-run.
- start deasserted mid-pass: ignored; the pass completes.
- banks_done deasserting mid-pass: ignored.
- Output read port:
  - out_rd_data <= buffer[out_rd_addr] one cycle after out_rd_en=1, otherwise held.
  - Addresses >= NEURONS return 0.
  - Reads are legal at any time. Data is guaranteed valid only when done=1.
- Reset mid-pass: aborts immediately. Outputs take reset values; a new start re-runs from neuron 0.
- BANKS=1: the sum is a single slice plus bias; the rest of the behaviour is unchanged.

Optional Feature:
- Macro: DENSE_COMBINE_SAT_EN.
- Defined:
  - A wide sum above +(2^(W-1)-1) clamps to the maximum W-bit value; a sum below -2^(W-1) clamps to the minimum.
  - Any clamp sets ovf_flag, which stays set until the next accepted start or reset.
- Undefined:
  - The wide sum is truncated to its low W bits (two's-complement wrap).
  - ovf_flag is tied to 0.

Test Plan:
- Defaults, banks_done=2'b11, start=1. Bank0=neuron*1.0, bank1=0.5, bias=-1.0 for every neuron → done at cycle 701; buffer[0]=0 (ReLU of -0.5); buffer[3]=2.5 (0x00A00).
- start=1 with banks_done=2'b01 for 20 cycles → stays in IDLE, busy=0. Set banks_done=2'b11 → pass begins the next cycle.
- DENSE_COMBINE_SAT_EN defined, both banks=+400.0, bias=+300.0 → output 0x7FFFF, ovf_flag=1. Without the macro: wrapped value, ovf_flag=0.
- ACT_MODE=0, BANKS=4, RD_LATENCY=2, NEURONS=8, slices {1,-2,3,-4}, bias 0 → every output is -2.0 (0xFF800); done at cycle 41.
- Drop reset_n at neuron 50 → busy=0, done=0 immediately. Restart → full pass completes; buffer[0..99] are correct.
- After done, read address 99 then address 120 → address 99 returns its correct value one cycle after out_rd_en; address 120 returns 0.
